// File: rtl/fib_stream_arbiter.sv
// Round-robin arbiter that shares one Fibonacci generator between two requesters,
// streaming N tagged terms per grant. Optional wrap detection under `FIB_OVF_EN`.
module fib_stream_arbiter #(
  parameter int DW    = 8,
  parameter int LEN_W = 5
) (
  input  logic             clk,
  input  logic             restart_n,
  input  logic [1:0]       req,
  input  logic [LEN_W-1:0] len0,
  input  logic [LEN_W-1:0] len1,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic             gen_restart,
  input  logic [DW-1:0]    gen_out,
  output logic [DW-1:0]    dout,
  output logic             dout_valid,
  output logic             dout_id,
  output logic             dout_last,
  output logic             busy
`ifdef FIB_OVF_EN
  ,
  output logic             ovf_err
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic             ptr_r, ptr_s;
  logic             gid_r, gid_s;
  logic [LEN_W-1:0] cnt_r, cnt_s;
  logic             abort_s;

  logic [1:0]       gnt_r, gnt_s;
  logic [1:0]       done_r, done_s;
  logic             gen_restart_r, gen_restart_s;
  logic             valid_r, valid_s;
  logic             id_r, id_s;
  logic             last_r, last_s;
  logic             busy_r, busy_s;

  // State register.
  always_ff @(posedge clk or negedge restart_n) begin
    if (!restart_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state, grant selection and term counter.
  always_comb begin
    state_s = state_r;
    ptr_s   = ptr_r;
    gid_s   = gid_r;
    cnt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (req != 2'b00) begin
          if (req[ptr_r]) begin
            gid_s = ptr_r;
          end else begin
            gid_s = ~ptr_r;
          end
          ptr_s   = ~gid_s;
          cnt_s   = gid_s ? len1 : len0;
          state_s = LOAD;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        if (cnt_r == {LEN_W{1'b0}}) begin
          state_s = IDLE;
        end else begin
          state_s = STREAM;
        end
      end
      STREAM: begin
        cnt_s = cnt_r - LEN_W'(1);
        if ((cnt_r <= LEN_W'(1)) || abort_s) begin
          state_s = IDLE;
        end else begin
          state_s = STREAM;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Output values for the coming cycle, decoded from the next state so they can be registered.
  always_comb begin
    gnt_s         = 2'b00;
    done_s        = 2'b00;
    gen_restart_s = 1'b1;
    valid_s       = 1'b0;
    id_s          = 1'b0;
    last_s        = 1'b0;
    busy_s        = 1'b0;
    case (state_s)
      LOAD: begin
        gnt_s  = gid_s ? 2'b10 : 2'b01;
        busy_s = 1'b1;
        if (cnt_s == {LEN_W{1'b0}}) begin
          done_s = gid_s ? 2'b10 : 2'b01;
        end else begin
          done_s = 2'b00;
        end
      end
      STREAM: begin
        gnt_s         = gid_s ? 2'b10 : 2'b01;
        busy_s        = 1'b1;
        gen_restart_s = 1'b0;
        valid_s       = 1'b1;
        id_s          = gid_s;
        if (cnt_s == LEN_W'(1)) begin
          last_s = 1'b1;
          done_s = gid_s ? 2'b10 : 2'b01;
        end else begin
          last_s = 1'b0;
          done_s = 2'b00;
        end
      end
      default: begin
        gnt_s = 2'b00;
      end
    endcase
  end

  // Datapath and registered outputs; the generator is held in restart whenever not streaming.
  always_ff @(posedge clk or negedge restart_n) begin
    if (!restart_n) begin
      ptr_r         <= 1'b0;
      gid_r         <= 1'b0;
      cnt_r         <= {LEN_W{1'b0}};
      gnt_r         <= 2'b00;
      done_r        <= 2'b00;
      gen_restart_r <= 1'b1;
      valid_r       <= 1'b0;
      id_r          <= 1'b0;
      last_r        <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      ptr_r         <= ptr_s;
      gid_r         <= gid_s;
      cnt_r         <= cnt_s;
      gnt_r         <= gnt_s;
      done_r        <= done_s;
      gen_restart_r <= gen_restart_s;
      valid_r       <= valid_s;
      id_r          <= id_s;
      last_r        <= last_s;
      busy_r        <= busy_s;
    end
  end

`ifdef FIB_OVF_EN
  logic [DW-1:0] prev_r;
  logic [1:0]    tidx_r;
  logic          ovf_s;

  // A term smaller than its predecessor (from the third term on) can only be a wrap.
  assign ovf_s   = (state_r == STREAM) && (tidx_r == 2'd2) && (gen_out < prev_r);
  assign abort_s = ovf_s;

  // Previous-term history, cleared outside STREAM.
  always_ff @(posedge clk or negedge restart_n) begin
    if (!restart_n) begin
      prev_r <= {DW{1'b0}};
      tidx_r <= 2'd0;
    end else if (state_r == STREAM) begin
      prev_r <= gen_out;
      tidx_r <= (tidx_r == 2'd2) ? 2'd2 : (tidx_r + 2'd1);
    end else begin
      prev_r <= {DW{1'b0}};
      tidx_r <= 2'd0;
    end
  end

  assign ovf_err    = ovf_s;
  assign dout_valid = valid_r & ~ovf_s;
  assign dout_last  = last_r & ~ovf_s;
  assign done       = ovf_s ? (id_r ? 2'b10 : 2'b01) : done_r;
`else
  assign abort_s    = 1'b0;
  assign dout_valid = valid_r;
  assign dout_last  = last_r;
  assign done       = done_r;
`endif

  assign gnt         = gnt_r;
  assign gen_restart = gen_restart_r;
  assign dout_id     = id_r;
  assign busy        = busy_r;
  assign dout        = dout_valid ? gen_out : {DW{1'b0}};

endmodule

// File: tb/tb_fib_stream_arbiter.sv
// Self-checking bench for fib_stream_arbiter: behavioural generator model plus a
// scoreboard of expected stream terms; wrap test adapts to FIB_OVF_EN.
module tb_fib_stream_arbiter;
  localparam int DW    = 8;
  localparam int LEN_W = 5;

  logic             clk = 1'b0;
  logic             restart_n = 1'b0;
  logic [1:0]       req = 2'b00;
  logic [LEN_W-1:0] len0 = '0;
  logic [LEN_W-1:0] len1 = '0;
  logic [1:0]       gnt, done;
  logic             gen_restart;
  logic [DW-1:0]    gen_out;
  logic [DW-1:0]    dout;
  logic             dout_valid, dout_id, dout_last, busy;
`ifdef FIB_OVF_EN
  logic             ovf_err;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          id;
    logic          last;
  } exp_t;
  exp_t sb_q[$];

  fib_stream_arbiter #(.DW(DW), .LEN_W(LEN_W)) dut (
    .clk(clk), .restart_n(restart_n), .req(req), .len0(len0), .len1(len1),
    .gnt(gnt), .done(done), .gen_restart(gen_restart), .gen_out(gen_out),
    .dout(dout), .dout_valid(dout_valid), .dout_id(dout_id),
    .dout_last(dout_last), .busy(busy)
`ifdef FIB_OVF_EN
    , .ovf_err(ovf_err)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural generator: restart loads term 0, otherwise advance one term.
  logic [DW-1:0] ga = 8'd0;
  logic [DW-1:0] gb = 8'd1;
  always @(posedge clk) begin
    if (gen_restart) begin
      ga <= 8'd0;
      gb <= 8'd1;
    end else begin
      ga <= gb;
      gb <= ga + gb;
    end
  end
  assign gen_out = ga;

  function automatic logic [DW-1:0] fib(input int n);
    logic [DW-1:0] a, b, t;
    a = 8'd0;
    b = 8'd1;
    for (int i = 0; i < n; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  task automatic push_job(input logic id, input int n, input int total);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.data = fib(i);
      e.id   = id;
      e.last = (i == total - 1);
      sb_q.push_back(e);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    exp_t e;
    if (dout_valid) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL stream_unexpected: dout=%0d id=%0d, required no valid term", dout, dout_id);
      end else begin
        e = sb_q.pop_front();
        if (dout !== e.data || dout_id !== e.id || dout_last !== e.last) begin
          errors++;
          $display("FAIL stream_term: dout=%0d id=%0d last=%0d, required dout=%0d id=%0d last=%0d",
                   dout, dout_id, dout_last, e.data, e.id, e.last);
        end
      end
    end else if (restart_n) begin
      checks++;
      if (dout !== 8'd0 || dout_last !== 1'b0) begin
        errors++;
        $display("FAIL idle_dout: dout=%0d last=%0d, required 0/0", dout, dout_last);
      end
    end
  end

  task automatic edge_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input logic [1:0] want, input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc && !ok; i++) begin
      @(negedge clk);
      if (done === want) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    restart_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (gen_restart !== 1'b1 || gnt !== 2'b00 || done !== 2'b00 || busy !== 1'b0 ||
        dout_valid !== 1'b0 || dout !== 8'd0 || dout_id !== 1'b0 || dout_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: gr=%0b gnt=%b done=%b busy=%0b v=%0b dout=%0d, required 1/00/00/0/0/0",
               gen_restart, gnt, done, busy, dout_valid, dout);
    end
    edge_drive();
    restart_n = 1'b1;
    @(negedge clk);
    checks++;
    if (gen_restart !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: gr=%0b busy=%0b, required 1/0", gen_restart, busy);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    edge_drive();
    req = 2'b11; len0 = 5'd3; len1 = 5'd2;
    push_job(1'b0, 3, 3);
    push_job(1'b1, 2, 2);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (gnt !== 2'b01) begin
      errors++;
      $display("FAIL b2b_first_grant: gnt=%b, required 01", gnt);
    end
    wait_done(2'b01, 10, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_done0: timeout, required done=01"); end
    edge_drive();
    req = 2'b10;
    @(negedge clk);
    checks++;
    if (gnt !== 2'b00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle_gap: gnt=%b busy=%0b, required 00/0", gnt, busy);
    end
    @(negedge clk);
    checks++;
    if (gnt !== 2'b10) begin
      errors++;
      $display("FAIL b2b_second_grant: gnt=%b, required 10", gnt);
    end
    wait_done(2'b10, 10, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_done1: timeout, required done=10"); end
    edge_drive();
    req = 2'b11; len0 = 5'd1; len1 = 5'd1;
    push_job(1'b0, 1, 1);
    push_job(1'b1, 1, 1);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (gnt !== 2'b01) begin
      errors++;
      $display("FAIL b2b_rr_regrant: gnt=%b, required 01", gnt);
    end
    wait_done(2'b01, 10, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_rr_done0: timeout, required done=01"); end
    edge_drive();
    req = 2'b10;
    wait_done(2'b10, 10, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_rr_done1: timeout, required done=10"); end
    edge_drive();
    req = 2'b00;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_drain: %0d terms left, required 0", sb_q.size());
    end
  endtask

  task automatic test_single();
    edge_drive();
    req = 2'b01; len0 = 5'd5;
    push_job(1'b0, 5, 5);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: busy=%0b, required 0", busy);
    end
    @(negedge clk);
    checks++;
    if (gnt !== 2'b01 || gen_restart !== 1'b1 || dout_valid !== 1'b0 || busy !== 1'b1 || done !== 2'b00) begin
      errors++;
      $display("FAIL single_load: gnt=%b gr=%0b v=%0b busy=%0b done=%b, required 01/1/0/1/00",
               gnt, gen_restart, dout_valid, busy, done);
    end
    len0 = 5'd9;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (dout_valid !== 1'b1 || gen_restart !== 1'b0 || done !== ((k == 4) ? 2'b01 : 2'b00)) begin
        errors++;
        $display("FAIL single_stream: k=%0d v=%0b gr=%0b done=%b, required 1/0/%b",
                 k, dout_valid, gen_restart, done, (k == 4) ? 2'b01 : 2'b00);
      end
    end
    edge_drive();
    req = 2'b00;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || gen_restart !== 1'b1 || done !== 2'b00 || gnt !== 2'b00) begin
      errors++;
      $display("FAIL single_end: busy=%0b gr=%0b done=%b gnt=%b, required 0/1/00/00",
               busy, gen_restart, done, gnt);
    end
  endtask

  task automatic test_zero_len();
    edge_drive();
    req = 2'b10; len1 = 5'd0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (gnt !== 2'b10 || done !== 2'b10 || dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL zero_len_load: gnt=%b done=%b v=%0b, required 10/10/0", gnt, done, dout_valid);
    end
    edge_drive();
    req = 2'b00;
    @(negedge clk);
    checks++;
    if (gnt !== 2'b00 || done !== 2'b00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_len_after: gnt=%b done=%b busy=%0b, required 00/00/0", gnt, done, busy);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    edge_drive();
    req = 2'b01; len0 = 5'd8;
    push_job(1'b0, 2, 8);
    repeat (4) @(negedge clk);
    edge_drive();
    restart_n = 1'b0;
    req = 2'b00;
    #1;
    checks++;
    if (gen_restart !== 1'b1 || gnt !== 2'b00 || done !== 2'b00 || busy !== 1'b0 ||
        dout_valid !== 1'b0 || dout !== 8'd0 || dout_last !== 1'b0 || dout_id !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: gr=%0b gnt=%b done=%b busy=%0b v=%0b dout=%0d, required 1/00/00/0/0/0",
               gen_restart, gnt, done, busy, dout_valid, dout);
    end
    @(negedge clk);
    checks++;
    if (done !== 2'b00 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_hold: done=%b left=%0d, required 00/0", done, sb_q.size());
    end
    edge_drive();
    restart_n = 1'b1;
    edge_drive();
    req = 2'b01; len0 = 5'd3;
    push_job(1'b0, 3, 3);
    wait_done(2'b01, 10, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL reset_mid_restart: timeout, required done=01"); end
    edge_drive();
    req = 2'b00;
  endtask

  task automatic test_wrap();
    bit ok;
    edge_drive();
    req = 2'b01; len0 = 5'd20;
`ifdef FIB_OVF_EN
    push_job(1'b0, 14, 20);
`else
    push_job(1'b0, 20, 20);
`endif
    wait_done(2'b01, 40, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL wrap_done: timeout, required done=01"); end
`ifdef FIB_OVF_EN
    checks++;
    if (ovf_err !== 1'b1 || dout_valid !== 1'b0 || dout_last !== 1'b0) begin
      errors++;
      $display("FAIL wrap_ovf: ovf=%0b v=%0b last=%0b, required 1/0/0", ovf_err, dout_valid, dout_last);
    end
`else
    checks++;
    if (dout_last !== 1'b1 || dout !== fib(19)) begin
      errors++;
      $display("FAIL wrap_last: last=%0b dout=%0d, required 1/%0d", dout_last, dout, fib(19));
    end
`endif
    edge_drive();
    req = 2'b00;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL wrap_end: busy=%0b left=%0d, required 0/0", busy, sb_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_single();
    test_zero_len();
    test_reset_mid();
    test_wrap();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
